uart_tx_word_serializer: RTL and testbench

//  Downstream stage of the memory/AES datapath. Buffers DATA_WIDTH-bit words from the memory

---
 rtl/uart_tx_word_serializer.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_word_serializer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_serializer.sv
// uart_tx_word_serializer
// Buffers words from the memory read port in a small FIFO, then feeds them
// byte by byte to a UART transmitter using its data_valid/busy handshake.
// Reports sticky overflow and an idle indication to the system controller.
module uart_tx_word_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic                          tx_busy,
    output logic [7:0]                    tx_data,
    output logic                          tx_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          idle
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;

    logic [DATA_WIDTH-1:0]   shift_word;
    logic [IDX_W-1:0]        byte_idx;

    logic                    push;
    logic                    pop;
    logic                    strobe;
    logic                    advance;

    // Pick byte number idx of the word in transmit order.
    function automatic logic [7:0] select_byte(input logic [DATA_WIDTH-1:0] w,
                                               input logic [IDX_W-1:0]      idx);
        int                    pos;
        logic [DATA_WIDTH-1:0] shifted;
        if (MSB_FIRST)
            pos = NBYTES - 1 - int'(idx);
        else
            pos = int'(idx);
        shifted = w >> (8 * pos);
        return shifted[7:0];
    endfunction

    // A full FIFO never accepts, even when the head is popped the same cycle.
    assign word_ready = (count != FULL_CNT);
    assign push       = word_valid && word_ready;
    assign fifo_count = count;
    assign idle       = (state == S_IDLE) && (count == '0);

    // FIFO storage: data only, contents are meaningless until pointed at.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= word_in;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: any word offered while full is lost; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (word_valid && !word_ready)
            overflow <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic: one byte per SEND -> WAIT_BUSY -> WAIT_DONE loop.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (count != '0)
                    state_next = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy)
                    state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy)
                    state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy)
                    state_next = (byte_idx == LAST_IDX) ? S_IDLE : S_SEND;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: pop the head, launch a byte, or step to the next byte.
    always_comb begin
        pop     = 1'b0;
        strobe  = 1'b0;
        advance = 1'b0;
        case (state)
            S_IDLE:      pop     = (count != '0);
            S_SEND:      strobe  = !tx_busy;
            S_WAIT_DONE: advance = !tx_busy && (byte_idx != LAST_IDX);
            default: begin
                pop     = 1'b0;
                strobe  = 1'b0;
                advance = 1'b0;
            end
        endcase
    end

    // Word being sent, byte index and the registered UART byte/strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_word    <= '0;
            byte_idx      <= '0;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
        end else begin
            tx_data_valid <= strobe;
            if (pop) begin
                shift_word <= mem[rd_ptr];
                byte_idx   <= '0;
            end else if (advance) begin
                byte_idx   <= byte_idx + IDX_W'(1);
            end
            if (strobe)
                tx_data <= select_byte(shift_word, byte_idx);
        end
    end

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Bench for uart_tx_word_serializer: two instances (LSB-first and MSB-first)
// share stimulus; a UART busy model answers strobes, and a byte-queue model
// predicts the transmitted stream from the accepted words.
module tb_uart_tx_word_serializer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] word_in;
    logic          word_valid;
    logic          tx_busy;

    logic          ready_l, ready_m;
    logic [7:0]    data_l, data_m;
    logic          valid_l, valid_m;
    logic [2:0]    cnt_l, cnt_m;
    logic          ovf_l, ovf_m;
    logic          idle_l, idle_m;

    int checks = 0;
    int errors = 0;

    bit hold_busy = 1'b0;
    int busy_len  = 10;
    int busy_left = 0;

    logic [7:0] exp_l[$];
    logic [7:0] exp_m[$];
    logic [7:0] got_l[$];
    logic [7:0] got_m[$];

    int          n;
    int          t;
    int          nw;
    logic [31:0] w;

    always #5 clk = ~clk;

    uart_tx_word_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(ready_l), .tx_busy(tx_busy), .tx_data(data_l),
        .tx_data_valid(valid_l), .fifo_count(cnt_l), .overflow(ovf_l), .idle(idle_l)
    );

    uart_tx_word_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(ready_m), .tx_busy(tx_busy), .tx_data(data_m),
        .tx_data_valid(valid_m), .fifo_count(cnt_m), .overflow(ovf_m), .idle(idle_m)
    );

    // UART model: busy rises one cycle after a strobe and stays up busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_left > 0)
                busy_left = busy_left - 1;
            if (valid_l === 1'b1)
                busy_left = busy_len + 1;
            tx_busy = hold_busy || (busy_left > 0 && busy_left <= busy_len);
        end
    end

    // Byte capture from both instances.
    always @(negedge clk) begin
        if (valid_l === 1'b1) got_l.push_back(data_l);
        if (valid_m === 1'b1) got_m.push_back(data_m);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] word, input int i, input bit msb);
        int k;
        k = msb ? (3 - i) : i;
        return word[8*k +: 8];
    endfunction

    function automatic void model_add(input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            exp_l.push_back(byte_of(word, i, 1'b0));
            exp_m.push_back(byte_of(word, i, 1'b1));
        end
    endfunction

    task automatic push_word(input logic [31:0] word, input bit accepted);
        word_in    = word;
        word_valid = 1'b1;
        if (accepted)
            model_add(word);
        @(negedge clk);
    endtask

    task automatic end_push();
        word_valid = 1'b0;
    endtask

    task automatic set_hold(input bit v);
        @(posedge clk);
        hold_busy = v;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!(idle_l === 1'b1 && idle_m === 1'b1) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle_reached"}, 32'(k < 5000), 32'd1);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_nbytes_lsb"}, 32'(got_l.size()), 32'(exp_l.size()));
        for (int i = 0; i < exp_l.size(); i++)
            chk({tag, "_byte_lsb"}, (i < got_l.size()) ? 32'(got_l[i]) : 32'hDEAD_BEEF, 32'(exp_l[i]));
        chk({tag, "_nbytes_msb"}, 32'(got_m.size()), 32'(exp_m.size()));
        for (int i = 0; i < exp_m.size(); i++)
            chk({tag, "_byte_msb"}, (i < got_m.size()) ? 32'(got_m[i]) : 32'hDEAD_BEEF, 32'(exp_m[i]));
        got_l.delete();
        got_m.delete();
        exp_l.delete();
        exp_m.delete();
    endtask

    initial begin
        rst        = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_tx_data", 32'(data_l), 32'h0);
        chk("rst_tx_valid", 32'(valid_l), 32'h0);
        chk("rst_overflow", 32'(ovf_l), 32'h0);
        chk("rst_fifo_count", 32'(cnt_l), 32'h0);
        chk("rst_word_ready", 32'(ready_l), 32'h1);
        chk("rst_idle", 32'(idle_l), 32'h1);
        chk("rst_idle_msb", 32'(idle_m), 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Single word, both byte orders, with latency check
        busy_len   = 10;
        word_in    = 32'hA1B2C3D4;
        word_valid = 1'b1;
        model_add(32'hA1B2C3D4);
        @(negedge clk);
        chk("lat_count_after_push", 32'(cnt_l), 32'd1);
        chk("lat_idle_after_push", 32'(idle_l), 32'd0);
        word_valid = 1'b0;
        @(negedge clk);
        chk("lat_count_after_pop", 32'(cnt_l), 32'd0);
        chk("lat_no_strobe_yet", 32'(valid_l), 32'd0);
        @(negedge clk);
        chk("lat_strobe", 32'(valid_l), 32'd1);
        chk("lat_first_lsb", 32'(data_l), 32'hD4);
        chk("lat_first_msb", 32'(data_m), 32'hA1);
        wait_idle("word1");
        check_bytes("word1");

        // Busy before the first byte holds the strobe off
        set_hold(1'b1);
        word_in    = 32'h5A6B7C8D;
        word_valid = 1'b1;
        model_add(32'h5A6B7C8D);
        @(negedge clk);
        word_valid = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_l === 1'b1) n++;
        end
        chk("busy_no_strobe", 32'(n), 32'd0);
        chk("busy_count_popped", 32'(cnt_l), 32'd0);
        chk("busy_not_idle", 32'(idle_l), 32'd0);
        set_hold(1'b0);
        chk("busy_release_pre", 32'(valid_l), 32'd0);
        @(negedge clk);
        chk("busy_release_strobe", 32'(valid_l), 32'd1);
        chk("busy_release_lsb", 32'(data_l), 32'h8D);
        chk("busy_release_msb", 32'(data_m), 32'h5A);
        @(negedge clk);
        chk("busy_strobe_one_cycle", 32'(valid_l), 32'd0);
        chk("busy_data_held", 32'(data_l), 32'h8D);
        wait_idle("busy");
        check_bytes("busy");

        // Fill to total capacity, sixth word dropped, overflow sticky
        set_hold(1'b1);
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                chk("full_ready_low", 32'(ready_l), 32'd0);
                chk("full_no_ovf_yet", 32'(ovf_l), 32'd0);
            end
            push_word(32'h0101_0101 * i + 32'h1000_0000, i <= 5);
        end
        end_push();
        chk("full_count", 32'(cnt_l), 32'd4);
        chk("full_overflow", 32'(ovf_l), 32'd1);
        chk("full_overflow_msb", 32'(ovf_m), 32'd1);
        @(negedge clk);
        chk("full_overflow_sticky", 32'(ovf_l), 32'd1);
        set_hold(1'b0);
        wait_idle("full");
        check_bytes("full");
        chk("ovf_kept_after_drain", 32'(ovf_l), 32'd1);

        // Push while IDLE pops with count==2
        busy_len = 10;
        push_word(32'hAAAA_0001, 1'b1);
        push_word(32'hBBBB_0002, 1'b1);
        push_word(32'hCCCC_0003, 1'b1);
        end_push();
        n = 0;
        t = 0;
        forever begin
            if (valid_l === 1'b1) n++;
            if (n == 4 || t == 2000) break;
            @(negedge clk);
            t++;
        end
        chk("pp_first_word_strobes", 32'(n), 32'd4);
        repeat (busy_len + 2) @(negedge clk);
        chk("pp_count_before", 32'(cnt_l), 32'd2);
        word_in    = 32'hDDDD_0004;
        word_valid = 1'b1;
        model_add(32'hDDDD_0004);
        @(negedge clk);
        word_valid = 1'b0;
        chk("pp_count_same", 32'(cnt_l), 32'd2);
        @(negedge clk);
        chk("pp_count_steady", 32'(cnt_l), 32'd2);
        wait_idle("pp");
        check_bytes("pp");

        // Reset while byte 2 is in flight
        word_in    = 32'h11223344;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_l.push_back(byte_of(32'h11223344, i, 1'b0));
            exp_m.push_back(byte_of(32'h11223344, i, 1'b1));
        end
        n = 0;
        t = 0;
        forever begin
            if (valid_l === 1'b1) n++;
            if (n == 2 || t == 2000) break;
            @(negedge clk);
            t++;
        end
        chk("mid_two_strobes", 32'(n), 32'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_data", 32'(data_l), 32'h0);
        chk("mid_rst_valid", 32'(valid_l), 32'h0);
        chk("mid_rst_overflow", 32'(ovf_l), 32'h0);
        chk("mid_rst_count", 32'(cnt_l), 32'h0);
        chk("mid_rst_ready", 32'(ready_l), 32'h1);
        chk("mid_rst_idle", 32'(idle_l), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_l === 1'b1 || valid_m === 1'b1) n++;
        end
        chk("mid_no_strobe_after", 32'(n), 32'd0);
        chk("mid_count_after", 32'(cnt_l), 32'd0);
        chk("mid_idle_after", 32'(idle_l), 32'd1);
        check_bytes("mid");

        // Randomized bursts under held busy, then drained with random busy times
        for (int it = 0; it < 10; it++) begin
            busy_len = int'($urandom_range(1, 6));
            nw       = int'($urandom_range(1, 5));
            set_hold(1'b1);
            for (int k = 0; k < nw; k++)
                push_word($urandom, 1'b1);
            end_push();
            @(negedge clk);
            chk("rnd_count", 32'(cnt_l), 32'(nw - 1));
            chk("rnd_ready", 32'(ready_l), 32'((nw - 1) < DEPTH));
            set_hold(1'b0);
            wait_idle("rnd");
            check_bytes("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
